// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result bundle for the pipelined barrel shifter.
// master drives operands and out_ready; slave is the shifter itself.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL): one registered mux level per
// shift-amount bit, MSB first, followed by a result register.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  barrel_shifter_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together when the result slot is empty or being
  // taken; otherwise every stage (bubbles included) holds. in_ready mirrors
  // that advance condition, so a held in_valid has no effect while stalled.
  logic advance;

  logic             v_q [SHW];
  logic [WIDTH-1:0] d_q [SHW];
  logic [SHW-1:0]   a_q [SHW];
  mode_e            m_q [SHW];
  logic             s_q [SHW];
  logic [WIDTH-1:0] step_d [SHW];

  logic             ov_q;
  logic [WIDTH-1:0] od_q;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input int               sh,
    input mode_e            mode,
    input logic             sign
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    res  = d;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (mode)
      MODE_LSL: res = d << sh;
      MODE_LSR: res = d >> sh;
      // Sign comes from the original operand, not the partially shifted data.
      MODE_ASR: res = (d >> sh) | fill;
      MODE_ROL: res = (d << sh) | (d >> (WIDTH - sh));
      default:  res = d;
    endcase
    return res;
  endfunction

  assign advance       = !ov_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_zero  = (od_q == '0);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic [SHW-1:0]   src_a;
    mode_e            src_m;
    logic             src_s;

    if (k == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src_d = bus.in_data;
      assign src_a = bus.in_amt;
      assign src_m = mode_e'(bus.in_mode);
      assign src_s = bus.in_data[WIDTH-1];
    end else begin : g_tail
      assign src_v = v_q[k-1];
      assign src_d = step_d[k-1];
      assign src_a = a_q[k-1];
      assign src_m = m_q[k-1];
      assign src_s = s_q[k-1];
    end

    // Stage k owns amount bit SHW-1-k, i.e. a shift of 2^(SHW-1-k).
    assign step_d[k] = a_q[k][SHW-1-k]
                     ? shift_step(d_q[k], 1 << (SHW-1-k), m_q[k], s_q[k])
                     : d_q[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        a_q[k] <= '0;
        m_q[k] <= MODE_LSL;
        s_q[k] <= 1'b0;
      end else if (advance) begin
        v_q[k] <= src_v;
        d_q[k] <= src_d;
        a_q[k] <= src_a;
        m_q[k] <= src_m;
        s_q[k] <= src_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
    end else if (advance) begin
      ov_q <= v_q[SHW-1];
      od_q <= step_d[SHW-1];
    end
  end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (WIDTH=16): single ops, a burst,
// a backpressure stall and an in-flight reset, against hand-computed results.
module tb_barrel_shifter_pipe;
  localparam int WIDTH = 16;
  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic clk;
  logic rst;

  barrel_shifter_pipe_if #(.WIDTH(WIDTH)) bus ();

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_out   = 0;
  int               first_out_cyc = 0;
  int               last_out_cyc  = 0;
  bit               lat_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // monitor: every output transfer is checked against the expected queue
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'(bus.out_data), 32'hDEAD_0000);
      end else begin
        logic [WIDTH-1:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e));
        check("out_zero", 32'(bus.out_zero), 32'(e == '0));
        if (lat_chk) check("latency", 32'(cyc - a), 32'd4);
        if (n_out == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_out++;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [15:0] d, input logic [3:0] a,
                      input logic [1:0] m, input logic [15:0] e);
    int g;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      check("send_timeout", 32'(g), 32'd0);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // directed single-op vectors: data, amt, mode, expected
  logic [15:0] sv_d[10] = '{16'h00FF, 16'h8001, 16'h8000, 16'h7FFF, 16'h8001,
                            16'h1234, 16'hFFFF, 16'h1234, 16'h8001, 16'h8001};
  logic [3:0]  sv_a[10] = '{4'd4, 4'd15, 4'd3, 4'd15, 4'd1, 4'd0, 4'd15, 4'd0, 4'd15, 4'd15};
  logic [1:0]  sv_m[10] = '{LSL, LSR, ASR, ASR, ROL, ROL, LSL, LSR, ASR, ROL};
  logic [15:0] sv_e[10] = '{16'h0FF0, 16'h0001, 16'hF000, 16'h0000, 16'h0003,
                            16'h1234, 16'h8000, 16'h1234, 16'hFFFF, 16'hC000};

  // back-to-back burst vectors
  logic [15:0] bv_d[8] = '{16'h1234, 16'h1234, 16'hF0F0, 16'h1234,
                           16'h4000, 16'hABCD, 16'hABCD, 16'h0003};
  logic [3:0]  bv_a[8] = '{4'd8, 4'd4, 4'd4, 4'd4, 4'd14, 4'd12, 4'd8, 4'd15};
  logic [1:0]  bv_m[8] = '{LSL, LSR, ASR, ROL, ASR, LSR, ROL, LSL};
  logic [15:0] bv_e[8] = '{16'h3400, 16'h0123, 16'hFF0F, 16'h2341,
                           16'h0001, 16'h000A, 16'hCDAB, 16'h8000};

  // stall vectors
  logic [15:0] st_d[5] = '{16'h00F0, 16'hFF00, 16'h8421, 16'h00AB, 16'h0001};
  logic [3:0]  st_a[5] = '{4'd12, 4'd8, 4'd1, 4'd4, 4'd1};
  logic [1:0]  st_m[5] = '{ROL, LSR, ASR, LSL, LSR};
  logic [15:0] st_e[5] = '{16'h000F, 16'h00FF, 16'hC210, 16'h0AB0, 16'h0000};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = LSL;
    bus.out_ready = 1'b1;

    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_zero",  32'(bus.out_zero),  32'd1);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // isolated operations, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(sv_d[i], sv_a[i], sv_m[i], sv_e[i]);
      wait_drain();
    end

    // back-to-back stream: 8 results on 8 consecutive cycles
    n_out = 0;
    for (int i = 0; i < 8; i++) send(bv_d[i], bv_a[i], bv_m[i], bv_e[i]);
    wait_drain();
    check("burst_count", 32'(n_out), 32'd8);
    check("burst_span",  32'(last_out_cyc - first_out_cyc), 32'd7);

    // backpressure: hold the head result for 5 cycles, then drain
    lat_chk = 1'b0;
    n_out = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(st_d[i], st_a[i], st_m[i], st_e[i]);
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 30) begin
          @(negedge clk);
          g++;
        end
        check("stall_fill", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready",  32'(bus.in_ready),  32'd0);
          check("stall_out_valid", 32'(bus.out_valid), 32'd1);
          check("stall_hold",      32'(bus.out_data),  32'h000F);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", 32'(n_out), 32'd5);

    // reset with three operations in flight
    n_out = 0;
    send(16'h1111, 4'd1, LSL, 16'h2222);
    send(16'h8000, 4'd2, ASR, 16'hE000);
    send(16'h0F0F, 4'd4, ROL, 16'hF0F0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    acc_q.delete();
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_zero",  32'(bus.out_zero),  32'd1);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(16'h0001, 4'd1, LSL, 16'h0002);
    wait_drain();
    check("post_rst_count", 32'(n_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
